pipeline_ctrl: RTL and testbench

//  Central sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.

---
 rtl/pipeline_ctrl_if.sv | 49 ++++
 rtl/pipeline_ctrl.sv | 117 +++++++++++
 tb/tb_pipeline_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_if.sv
// Hazard/status inputs and stage-control outputs between the datapath and pipeline_ctrl.
// PIPECTRL_PERF_EN adds the stall_cnt/flush_cnt performance counters to the bundle.
interface pipeline_ctrl_if;
   logic       ihit;
   logic       dhit;
   logic       exmem_dREN;
   logic       exmem_dWEN;
   logic       idex_MemRead;
   logic [4:0] idex_rt;
   logic [4:0] ifid_rs;
   logic [4:0] ifid_rt;
   logic       jump_id;
   logic       branch_taken;
   logic       halt_wb;
   logic       pc_WEN;
   logic       ifid_WEN;
   logic       ifid_flush;
   logic       idex_WEN;
   logic       idex_flush;
   logic       exmem_WEN;
   logic       exmem_flush;
   logic       memwb_WEN;
   logic       halted;
   logic       mem_timeout;
`ifdef PIPECTRL_PERF_EN
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;
`endif

   modport master (
      output ihit, dhit, exmem_dREN, exmem_dWEN, idex_MemRead, idex_rt,
             ifid_rs, ifid_rt, jump_id, branch_taken, halt_wb,
`ifdef PIPECTRL_PERF_EN
      input  stall_cnt, flush_cnt,
`endif
      input  pc_WEN, ifid_WEN, ifid_flush, idex_WEN, idex_flush,
             exmem_WEN, exmem_flush, memwb_WEN, halted, mem_timeout
   );

   modport slave (
      input  ihit, dhit, exmem_dREN, exmem_dWEN, idex_MemRead, idex_rt,
             ifid_rs, ifid_rt, jump_id, branch_taken, halt_wb,
`ifdef PIPECTRL_PERF_EN
      output stall_cnt, flush_cnt,
`endif
      output pc_WEN, ifid_WEN, ifid_flush, idex_WEN, idex_flush,
             exmem_WEN, exmem_flush, memwb_WEN, halted, mem_timeout
   );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: stage enables/flushes, PC enable, RUN/DWAIT/HALTED FSM and data-wait watchdog.
// Optional PIPECTRL_PERF_EN macro adds stall and flush cycle counters.
module pipeline_ctrl #(
   parameter int DWAIT_MAX = 16
) (
   input  logic              CLK,
   input  logic              nRST,
   pipeline_ctrl_if.slave    bus
);

   typedef enum logic [1:0] {RUN, DWAIT, HALTED} state_e;

   localparam logic [4:0] WMAX = 5'(DWAIT_MAX);

   state_e     state_q, state_d;
   logic [4:0] wcnt_q, wcnt_d;
   logic       timeout_q, timeout_d;

   logic dstall, load_use;
   logic pc_wen, ifid_wen, ifid_fl, idex_wen, idex_fl, exmem_wen, exmem_fl, memwb_wen;

   assign dstall   = (bus.exmem_dREN | bus.exmem_dWEN) & ~bus.dhit;
   assign load_use = bus.idex_MemRead & (bus.idex_rt != 5'd0) &
                     ((bus.idex_rt == bus.ifid_rs) | (bus.idex_rt == bus.ifid_rt));

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q   <= RUN;
         wcnt_q    <= 5'd0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wcnt_q    <= wcnt_d;
         timeout_q <= timeout_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_wen    = 1'b0;
      ifid_wen  = 1'b0;
      ifid_fl   = 1'b0;
      idex_wen  = 1'b0;
      idex_fl   = 1'b0;
      exmem_wen = 1'b0;
      exmem_fl  = 1'b0;
      memwb_wen = 1'b0;

      // Reset and HALTED both leave every enable and flush low.
      if (nRST && state_q != HALTED) begin
         if (bus.halt_wb) begin
            state_d = HALTED;
         end else if (dstall) begin
            state_d = DWAIT;
         end else begin
            state_d   = RUN;
            pc_wen    = 1'b1;
            ifid_wen  = 1'b1;
            idex_wen  = 1'b1;
            exmem_wen = 1'b1;
            memwb_wen = 1'b1;
            if (bus.branch_taken) begin
               ifid_fl  = 1'b1;
               idex_fl  = 1'b1;
               exmem_fl = 1'b1;
            end else if (load_use) begin
               pc_wen   = 1'b0;
               ifid_wen = 1'b0;
               idex_fl  = 1'b1;
            end else if (bus.jump_id) begin
               ifid_fl = 1'b1;
            end else if (!bus.ihit) begin
               pc_wen  = 1'b0;
               ifid_fl = 1'b1;
            end
         end
      end

      if (state_q == DWAIT)
         wcnt_d = (wcnt_q == WMAX) ? wcnt_q : wcnt_q + 5'd1;
      else
         wcnt_d = 5'd0;
      timeout_d = timeout_q | (wcnt_d == WMAX);
   end

   assign bus.pc_WEN      = pc_wen;
   assign bus.ifid_WEN    = ifid_wen;
   assign bus.ifid_flush  = ifid_fl;
   assign bus.idex_WEN    = idex_wen;
   assign bus.idex_flush  = idex_fl;
   assign bus.exmem_WEN   = exmem_wen;
   assign bus.exmem_flush = exmem_fl;
   assign bus.memwb_WEN   = memwb_wen;
   assign bus.halted      = (state_q == HALTED);
   assign bus.mem_timeout = timeout_q;

`ifdef PIPECTRL_PERF_EN
   logic [31:0] stall_cnt_q, flush_cnt_q;

   // Stalls count only while the pipeline is live, not once halted.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stall_cnt_q <= 32'd0;
         flush_cnt_q <= 32'd0;
      end else begin
         if (state_q != HALTED && !pc_wen)
            stall_cnt_q <= stall_cnt_q + 32'd1;
         if (ifid_fl | idex_fl | exmem_fl)
            flush_cnt_q <= flush_cnt_q + 32'd1;
      end
   end

   assign bus.stall_cnt = stall_cnt_q;
   assign bus.flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed-vector scoreboard bench for pipeline_ctrl: driver queues expected outputs, monitor checks.
module tb_pipeline_ctrl;

   logic CLK;
   logic nRST;

   pipeline_ctrl_if bus ();

   pipeline_ctrl #(.DWAIT_MAX(16)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [9:0] exp;
      string      name;
   } sb_t;

   sb_t sb_q[$];
   int  checks = 0;
   int  errors = 0;

   // Input control word bits
   localparam logic [8:0] R  = 9'h100, IH = 9'h080, DH = 9'h040, DR = 9'h020, DW = 9'h010,
                          MR = 9'h008, JP = 9'h004, BR = 9'h002, HL = 9'h001;

   // Expected output word: pc ifw iff idw idf exw exf mw halted timeout
   localparam logic [9:0] E_NORM = 10'b1101010100;
   localparam logic [9:0] E_LU   = 10'b0001110100;
   localparam logic [9:0] E_BR   = 10'b1111111100;
   localparam logic [9:0] E_JMP  = 10'b1111010100;
   localparam logic [9:0] E_NOIH = 10'b0111010100;
   localparam logic [9:0] E_ZERO = 10'b0000000000;
   localparam logic [9:0] E_TO   = 10'b0000000001;
   localparam logic [9:0] E_HLT  = 10'b0000000010;

   task automatic drive(input logic [8:0] c, input logic [4:0] xrt, input logic [4:0] frs,
                        input logic [4:0] frt, input logic [9:0] exp, input string nm);
      sb_t e;
      @(posedge CLK);
      #1;
      nRST             = c[8];
      bus.ihit         = c[7];
      bus.dhit         = c[6];
      bus.exmem_dREN   = c[5];
      bus.exmem_dWEN   = c[4];
      bus.idex_MemRead = c[3];
      bus.jump_id      = c[2];
      bus.branch_taken = c[1];
      bus.halt_wb      = c[0];
      bus.idex_rt      = xrt;
      bus.ifid_rs      = frs;
      bus.ifid_rt      = frt;
      e.exp  = exp;
      e.name = nm;
      sb_q.push_back(e);
   endtask

   initial begin : monitor
      sb_t        e;
      logic [9:0] got;
      forever begin
         @(negedge CLK);
         if (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            got = {bus.pc_WEN, bus.ifid_WEN, bus.ifid_flush, bus.idex_WEN, bus.idex_flush,
                   bus.exmem_WEN, bus.exmem_flush, bus.memwb_WEN, bus.halted, bus.mem_timeout};
            checks++;
            if (got !== e.exp) begin
               errors++;
               $display("FAIL %s got %b want %b", e.name, got, e.exp);
            end
         end
      end
   end

   initial begin : driver
      int waited;
      nRST             = 1'b0;
      bus.ihit         = 1'b1;
      bus.dhit         = 1'b0;
      bus.exmem_dREN   = 1'b0;
      bus.exmem_dWEN   = 1'b0;
      bus.idex_MemRead = 1'b0;
      bus.jump_id      = 1'b0;
      bus.branch_taken = 1'b0;
      bus.halt_wb      = 1'b0;
      bus.idex_rt      = 5'd0;
      bus.ifid_rs      = 5'd0;
      bus.ifid_rt      = 5'd0;

      drive(IH, 0, 0, 0, E_ZERO, "reset0");
      drive(IH, 0, 0, 0, E_ZERO, "reset1");
      for (int i = 0; i < 3; i++) drive(R | IH, 0, 0, 0, E_NORM, "idle");

      drive(R | IH | MR, 5, 5, 0, E_LU,   "lu_rs");
      drive(R | IH | MR, 5, 0, 5, E_LU,   "lu_rt");
      drive(R | IH | MR, 0, 0, 0, E_NORM, "lu_rt0");
      drive(R | IH | MR, 5, 6, 7, E_NORM, "lu_nomatch");
      drive(R | IH | JP, 0, 0, 0, E_JMP,  "jump");
      drive(R,           0, 0, 0, E_NOIH, "no_ihit");
      drive(R | JP,      0, 0, 0, E_JMP,  "jump_over_ihit");

      for (int i = 0; i < 3; i++) drive(R | IH | DR, 0, 0, 0, E_ZERO, "dwait_freeze");
      drive(R | IH | DR | DH, 0, 0, 0, E_NORM, "dwait_hit");
      drive(R | IH,           0, 0, 0, E_NORM, "after_dwait");

      drive(R | IH | BR | MR, 5, 5, 0, E_BR,   "br_over_lu");
      drive(R | IH | DR,      0, 0, 0, E_ZERO, "br_dw_freeze");
      drive(R | IH | DR | DH | BR, 0, 0, 0, E_BR, "br_with_dhit");
      drive(R | IH | BR | DR, 0, 0, 0, E_ZERO, "dstall_over_br");
      drive(R | IH | DH | DR, 0, 0, 0, E_NORM, "dwait_hit2");

      for (int i = 0; i < 20; i++)
         drive(R | IH | DW, 0, 0, 0, (i >= 17) ? E_TO : E_ZERO, "watchdog");
      drive(R | IH | DW | DH, 0, 0, 0, E_NORM | E_TO, "wd_release");
      drive(R | IH,           0, 0, 0, E_NORM | E_TO, "wd_sticky");

      drive(R | IH | HL,      0, 0, 0, E_TO,          "halt_cycle");
      drive(R | IH | BR | JP, 0, 0, 0, E_HLT | E_TO,  "halted_br");
      drive(R | MR,           5, 5, 0, E_HLT | E_TO,  "halted_lu");
      drive(R | IH,           0, 0, 0, E_HLT | E_TO,  "halted_idle");
      drive(IH,               0, 0, 0, E_ZERO,        "halt_reset");
      drive(R | IH,           0, 0, 0, E_NORM,        "post_reset");

      drive(R | IH | DR, 0, 0, 0, E_ZERO, "rst_dw_freeze");
      drive(IH | DR,     0, 0, 0, E_ZERO, "rst_mid_dwait");
      drive(R | IH,      0, 0, 0, E_NORM, "rst_dw_run");

      waited = 0;
      while (sb_q.size() > 0 && waited < 10) begin
         @(posedge CLK);
         waited++;
      end
      if (sb_q.size() > 0) begin
         errors++;
         $display("FAIL drain got %0d pending want 0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
